// File: rtl/dc_rep_download_if.sv
// Ring-side flit stream and consumer-side reply handshake for the data-cache reply download path.
// The master modport is the ring sender plus reply consumer; the slave modport is the download block.
interface dc_rep_download_if;
  localparam int unsigned FLIT_W = 16;
  localparam int unsigned MSG_W  = 176;
  localparam int unsigned CNT_W  = 4;

  logic              v_flit_in;
  logic [FLIT_W-1:0] flit_in;
  logic              flit_rdy;
  logic [MSG_W-1:0]  dc_flits_rep;
  logic              v_dc_flits_rep;
  logic [CNT_W-1:0]  dc_flits_max;
  logic              dc_rep_deq;
  logic [1:0]        dc_rep_download_state;

  modport master (
    output v_flit_in, flit_in, dc_rep_deq,
    input  flit_rdy, dc_flits_rep, v_dc_flits_rep, dc_flits_max, dc_rep_download_state
  );

  modport slave (
    input  v_flit_in, flit_in, dc_rep_deq,
    output flit_rdy, dc_flits_rep, v_dc_flits_rep, dc_flits_max, dc_rep_download_state
  );
endinterface

// File: rtl/dc_rep_download.sv
// Reassembles 16-bit reply flits into a 176-bit data-cache reply message (up to 11 flits),
// with the length taken from the head flit, and holds it until the consumer dequeues it.
module dc_rep_download (
  input  logic               clk,
  input  logic               rst,
  dc_rep_download_if.slave   bus
);
  localparam int unsigned FLIT_W    = 16;
  localparam int unsigned NUM_FLITS = 11;
  localparam int unsigned MSG_W     = FLIT_W * NUM_FLITS;
  localparam int unsigned CNT_W     = 4;
  localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(NUM_FLITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FULL = 2'b10
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_max;
  logic [MSG_W-1:0]   r_msg;
  logic               r_flit_rdy;
  logic               r_v_rep;

  logic               w_xfer;
  logic [CNT_W-1:0]   w_head_max;

  assign w_xfer     = bus.v_flit_in & r_flit_rdy;
  // Oversized length fields in the head flit are clamped to the last physical slot.
  assign w_head_max = (bus.flit_in[CNT_W-1:0] > MAX_IDX) ? MAX_IDX : bus.flit_in[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_max      <= '0;
      r_msg      <= '0;
      r_flit_rdy <= 1'b1;
      r_v_rep    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_msg[MSG_W-1 -: FLIT_W] <= bus.flit_in;
            r_max                    <= w_head_max;
            if (w_head_max == '0) begin
              r_state    <= FULL;
              r_flit_rdy <= 1'b0;
              r_v_rep    <= 1'b1;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (w_xfer) begin
            for (int k = 0; k < NUM_FLITS; k++) begin
              if (r_cnt == CNT_W'(k)) r_msg[MSG_W-1-FLIT_W*k -: FLIT_W] <= bus.flit_in;
            end
            if (r_cnt == r_max) begin
              r_state    <= FULL;
              r_flit_rdy <= 1'b0;
              r_v_rep    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        FULL: begin
          // Clearing on dequeue keeps slots above the next message's length at zero.
          if (bus.dc_rep_deq) begin
            r_msg      <= '0;
            r_cnt      <= '0;
            r_max      <= '0;
            r_state    <= IDLE;
            r_flit_rdy <= 1'b1;
            r_v_rep    <= 1'b0;
          end
        end
        default: begin
          r_msg      <= '0;
          r_cnt      <= '0;
          r_max      <= '0;
          r_state    <= IDLE;
          r_flit_rdy <= 1'b1;
          r_v_rep    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flit_rdy              = r_flit_rdy;
  assign bus.v_dc_flits_rep        = r_v_rep;
  assign bus.dc_flits_rep          = r_msg;
  assign bus.dc_flits_max          = r_max;
  assign bus.dc_rep_download_state = r_state;
endmodule

// File: tb/tb_dc_rep_download.sv
// Self-checking bench for dc_rep_download: directed scenarios plus randomized messages
// checked against a message-level reference model.
module tb_dc_rep_download;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dc_rep_download_if bus ();
  dc_rep_download dut (.clk(clk), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] fl [11];

  // Observed bundle: {state, flit_rdy, v_rep, max, msg}
  function automatic logic [183:0] snap();
    return {bus.dc_rep_download_state, bus.flit_rdy, bus.v_dc_flits_rep, bus.dc_flits_max, bus.dc_flits_rep};
  endfunction

  function automatic logic [3:0] model_max(input logic [15:0] head);
    return (head[3:0] > 4'd10) ? 4'd10 : head[3:0];
  endfunction

  // Expected message: flits 0..max placed at slot k, everything else zero.
  function automatic logic [175:0] model_msg();
    logic [175:0] m = '0;
    int mx = int'(model_max(fl[0]));
    for (int k = 0; k <= mx; k++) m = m | (176'(fl[k]) << (160 - 16 * k));
    return m;
  endfunction

  function automatic logic [183:0] exp_full();
    return {2'b10, 1'b0, 1'b1, model_max(fl[0]), model_msg()};
  endfunction

  function automatic logic [183:0] exp_idle();
    return {2'b00, 1'b1, 1'b0, 4'd0, 176'd0};
  endfunction

  task automatic bubble();
    @(negedge clk);
    bus.v_flit_in = 1'b0;
  endtask

  task automatic send_flit(input logic [15:0] f, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      bus.v_flit_in = 1'b1;
      bus.flit_in   = f;
      if (bus.flit_rdy === 1'b1) ok = 1'b1;
      n++;
    end
  endtask

  task automatic send_msg(input int first, input int last, input int maxgap, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = first; i <= last; i++) begin
      for (int g = 0; g < int'($urandom_range(maxgap, 0)); g++) bubble();
      send_flit(fl[i], o);
      ok &= o;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.v_flit_in = 1'b0; bus.flit_in = '0; bus.dc_rep_deq = 1'b0;
    #1;
    compared++;
    if (snap() !== exp_idle()) begin mismatched++; $display("FAIL reset_state got=%h exp=%h", snap(), exp_idle()); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (snap() !== exp_idle()) begin mismatched++; $display("FAIL after_reset got=%h exp=%h", snap(), exp_idle()); end
  endtask

  task automatic test_single();
    bit ok;
    fl[0] = 16'hA000;
    send_flit(fl[0], ok);
    bubble();
    compared++;
    if (!ok || snap() !== exp_full()) begin mismatched++; $display("FAIL single_full ok=%0d got=%h exp=%h", ok, snap(), exp_full()); end
    bus.dc_rep_deq = 1'b1;
    @(negedge clk);
    bus.dc_rep_deq = 1'b0;
    compared++;
    if (snap() !== exp_idle()) begin mismatched++; $display("FAIL single_deq got=%h exp=%h", snap(), exp_idle()); end
  endtask

  task automatic test_full11();
    bit ok, o;
    fl[0] = 16'h100A;
    for (int k = 1; k <= 10; k++) fl[k] = 16'(k);
    send_msg(0, 9, 0, ok);
    send_flit(fl[10], o);
    compared++;
    if (!(ok && o) || bus.v_dc_flits_rep !== 1'b0) begin mismatched++; $display("FAIL full11_early_valid ok=%0d got=%b exp=0", ok && o, bus.v_dc_flits_rep); end
    bubble();
    compared++;
    if (snap() !== exp_full()) begin mismatched++; $display("FAIL full11_msg got=%h exp=%h", snap(), exp_full()); end
    bus.dc_rep_deq = 1'b1;
    @(negedge clk);
    bus.dc_rep_deq = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok, o;
    fl[0] = 16'h0003; fl[1] = 16'h1111; fl[2] = 16'h2222; fl[3] = 16'h3333;
    send_flit(fl[0], ok); bubble();
    send_flit(fl[1], o); ok &= o; bubble(); bubble();
    send_flit(fl[2], o); ok &= o;
    send_flit(fl[3], o); ok &= o;
    // Hold the next message's head on the bus while the reply sits unconsumed.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.v_flit_in = 1'b1; bus.flit_in = 16'hFFFF;
      compared++;
      if (!ok || snap() !== exp_full()) begin mismatched++; $display("FAIL bp_hold%0d ok=%0d got=%h exp=%h", c, ok, snap(), exp_full()); end
    end
    bus.dc_rep_deq = 1'b1;
    @(negedge clk);
    bus.dc_rep_deq = 1'b0;
    compared++;
    if (snap() !== exp_idle()) begin mismatched++; $display("FAIL bp_deq_no_absorb got=%h exp=%h", snap(), exp_idle()); end
    bubble();
    compared++;
    if (bus.dc_rep_download_state !== 2'b01 || bus.dc_flits_rep[175:160] !== 16'hFFFF) begin
      mismatched++; $display("FAIL bp_new_head state=%b slot0=%h exp state=01 slot0=ffff", bus.dc_rep_download_state, bus.dc_flits_rep[175:160]);
    end
    fl[0] = 16'hFFFF;
    for (int k = 1; k <= 10; k++) fl[k] = 16'($urandom);
    send_msg(1, 10, 1, ok);
    bubble();
    compared++;
    if (!ok || snap() !== exp_full()) begin mismatched++; $display("FAIL bp_second_msg ok=%0d got=%h exp=%h", ok, snap(), exp_full()); end
    bus.dc_rep_deq = 1'b1;
    @(negedge clk);
    bus.dc_rep_deq = 1'b0;
  endtask

  task automatic test_clamp();
    bit ok;
    int n = 0;
    fl[0] = 16'h000F;
    for (int k = 1; k <= 10; k++) fl[k] = 16'($urandom);
    // Count flits until the block stops accepting; must be exactly 11.
    while (bus.dc_rep_download_state !== 2'b10 && n < 20) begin
      send_flit(fl[n % 11], ok);
      n++;
      bubble();
    end
    compared++;
    if (n != 11 || snap() !== exp_full()) begin mismatched++; $display("FAIL clamp flits=%0d exp_flits=11 got=%h exp=%h", n, snap(), exp_full()); end
    bus.dc_rep_deq = 1'b1;
    @(negedge clk);
    bus.dc_rep_deq = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    fl[0] = 16'h0005; fl[1] = 16'hBEEF; fl[2] = 16'hCAFE;
    send_msg(0, 2, 0, ok);
    bubble();
    rst = 1'b1;
    #1;
    compared++;
    if (!ok || snap() !== exp_idle()) begin mismatched++; $display("FAIL reset_mid ok=%0d got=%h exp=%h", ok, snap(), exp_idle()); end
    @(negedge clk);
    rst = 1'b0;
    fl[0] = 16'h0001; fl[1] = 16'h5A5A;
    send_msg(0, 1, 0, ok);
    bubble();
    compared++;
    if (!ok || snap() !== exp_full()) begin mismatched++; $display("FAIL reset_mid_next ok=%0d got=%h exp=%h", ok, snap(), exp_full()); end
    bus.dc_rep_deq = 1'b1;
    @(negedge clk);
    bus.dc_rep_deq = 1'b0;
  endtask

  task automatic test_spurious_deq();
    bit ok, o;
    @(negedge clk);
    bus.dc_rep_deq = 1'b1;
    @(negedge clk);
    bus.dc_rep_deq = 1'b0;
    compared++;
    if (snap() !== exp_idle()) begin mismatched++; $display("FAIL deq_in_idle got=%h exp=%h", snap(), exp_idle()); end
    fl[0] = 16'h0002; fl[1] = 16'h1234; fl[2] = 16'h5678;
    send_msg(0, 0, 0, ok);
    bus.dc_rep_deq = 1'b1;
    send_flit(fl[1], o); ok &= o;
    bubble();
    bus.dc_rep_deq = 1'b0;
    compared++;
    if (bus.dc_rep_download_state !== 2'b01) begin mismatched++; $display("FAIL deq_in_busy state=%b exp=01", bus.dc_rep_download_state); end
    send_flit(fl[2], o); ok &= o;
    bubble();
    compared++;
    if (!ok || snap() !== exp_full()) begin mismatched++; $display("FAIL deq_busy_msg ok=%0d got=%h exp=%h", ok, snap(), exp_full()); end
    bus.dc_rep_deq = 1'b1;
    @(negedge clk);
    bus.dc_rep_deq = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    for (int m = 0; m < 40; m++) begin
      for (int k = 0; k < 11; k++) fl[k] = 16'($urandom);
      send_msg(0, int'(model_max(fl[0])), 2, ok);
      bubble();
      for (int h = 0; h < int'($urandom_range(3, 0)); h++) bubble();
      compared++;
      if (!ok || snap() !== exp_full()) begin mismatched++; $display("FAIL rand_msg%0d ok=%0d got=%h exp=%h", m, ok, snap(), exp_full()); end
      bus.dc_rep_deq = 1'b1;
      @(negedge clk);
      bus.dc_rep_deq = 1'b0;
      compared++;
      if (snap() !== exp_idle()) begin mismatched++; $display("FAIL rand_deq%0d got=%h exp=%h", m, snap(), exp_idle()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full11();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    test_spurious_deq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dc_rep_download.md
# dc_rep_download

Receive-side counterpart of the data-cache reply upload path. The block accepts a stream of 16-bit reply flits from the ring interface and reassembles them into a 176-bit reply message of up to 11 flits. It holds the assembled message until the downstream consumer (data-cache reply handler) takes it. The message length is decoded from the head flit, so no side-band length signal is required.

## Interface
Parameters: none (widths fixed: flit 16 bits, message 176 bits = 11 flits).

- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- v_flit_in  input  1  flit_in is valid this cycle
- flit_in  input  16  incoming flit; head flit bits [3:0] = index of last flit (flits_max)
- flit_rdy  output  1  block accepts a flit this cycle; a flit transfers when v_flit_in && flit_rdy
- dc_flits_rep  output  176  assembled message; flit k occupies bits [175-16k : 160-16k]
- v_dc_flits_rep  output  1  dc_flits_rep is complete and stable
- dc_flits_max  output  4  captured last-flit index of the held message (0..10)
- dc_rep_deq  input  1  consumer takes the held message; honoured only while v_dc_flits_rep=1
- dc_rep_download_state  output  2  current FSM state encoding

## Operation
- FSM states: IDLE=2'b00, BUSY=2'b01, FULL=2'b10; 2'b11 is unused and recovers to IDLE on the next edge.
- IDLE:
  - flit_rdy=1.
  - On a transfer, write flit_in into slot 0 (bits [175:160]).
  - Capture max = (flit_in[3:0] > 10) ? 10 : flit_in[3:0].
  - If max==0, go to FULL; else set cnt=1 and go to BUSY.
- BUSY:
  - flit_rdy=1.
  - On a transfer, write flit_in into slot cnt.
  - If cnt==max, go to FULL; else cnt<=cnt+1.
  - Cycles without v_flit_in hold all state (bubbles allowed).
- FULL:
  - flit_rdy=0, v_dc_flits_rep=1.
  - On dc_rep_deq: clear the message register to 0, clear cnt and max to 0, go to IDLE.
  - Without dc_rep_deq: hold indefinitely.
- Slots above max stay 0, because the message register is cleared on deq and on reset.
- A flit presented while flit_rdy=0 is not consumed; the sender holds it.
- dc_rep_deq in IDLE or BUSY is ignored.
- cnt is 4 bits, never exceeds 10, and never wraps.
- dc_flits_max reflects the captured max and is valid whenever v_dc_flits_rep=1.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, cnt=0, max=0, message register=0.
  - Outputs: flit_rdy=1, v_dc_flits_rep=0, dc_flits_rep=0, dc_flits_max=0, dc_rep_download_state=2'b00.
- Reset mid-message discards the partial message; the next accepted flit is treated as a head flit.
- All outputs are registered or decoded from registered state only. flit_rdy has no combinational path from v_flit_in or dc_rep_deq.
- Latency: v_dc_flits_rep rises on the clock edge that captures the last flit (visible the following cycle).
- Back-to-back operation:
  - The first flit of the next message is accepted no earlier than the cycle after the deq edge.
  - Minimum period per message is max+2 cycles (max+1 flit cycles plus one FULL cycle with same-cycle deq).
- Simultaneous dc_rep_deq and v_flit_in in FULL: deq is taken, the flit is not (flit_rdy=0).
- Throughput in BUSY: one flit per cycle.

## Test plan
- Single-flit message: head 16'hA000 (max=0) in IDLE.
  - Required: next cycle v_dc_flits_rep=1, dc_flits_rep[175:160]=16'hA000, all other bits 0, dc_flits_max=0, flit_rdy=0.
  - Pulse deq: IDLE, flit_rdy=1, dc_flits_rep=0.
- Full 11-flit message: head 16'h100A, then 16'h0001..16'h000A on consecutive cycles.
  - Required: v_dc_flits_rep=1 exactly one cycle after the 11th flit; slot k = k for k=1..10; dc_flits_max=10.
- Bubbles and backpressure: 4-flit message (head 16'h0003) with v_flit_in gaps.
  - Extra flit 16'hFFFF is held on v_flit_in while FULL for 5 cycles, then deq.
  - Required: assembled slots correct; 16'hFFFF is not absorbed until after deq, then becomes the head of the next message.
- Length clamp: head 16'h000F followed by 10 flits.
  - Required: FULL after exactly 11 flits, dc_flits_max=10.
- Reset mid-operation: assert rst after 3 of 6 flits.
  - Required: immediately state=2'b00, all outputs at reset values.
  - A new 2-flit message (head 16'h0001) then assembles correctly with no residue from the aborted message.
- Spurious deq: pulse dc_rep_deq in IDLE and in BUSY.
  - Required: no state change; message assembly unaffected.
